// File: rtl/complex_mult_pkg.sv
// Shared encodings for the complex-multiplier traffic generator: modes, FSM states,
// result width and the LFSR feedback polynomial.
package complex_mult_pkg;

    localparam logic [1:0] MODE_FIXED  = 2'd0;
    localparam logic [1:0] MODE_RANDOM = 2'd1;
    localparam logic [1:0] MODE_ONES   = 2'd2;
    localparam logic [1:0] MODE_MINNEG = 2'd3;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned RES_W          = 2 * DEF_DATA_WIDTH + 2;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StGap,
        StDrive,
        StWaitRes,
        StCheck,
        StDone
    } state_e;

    // Two full products plus one carry bit and one sign bit never overflow.
    function automatic int unsigned res_width(input int unsigned dw);
        return 2 * dw + 2;
    endfunction

endpackage

// File: rtl/complex_mult_lfsr.sv
// 32-bit Galois LFSR: loads the seed on reset, shifts right by one on each advance request.
module complex_mult_lfsr
    import complex_mult_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_F00D
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        adv_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (adv_i) begin
            state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR_POLY : 32'h0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/complex_mult_traffic_gen.sv
// Stimulus generator and result checker for the complex multiplier: issues one operand
// transaction at a time, compares each returned product against a registered golden value.
module complex_mult_traffic_gen
    import complex_mult_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TXN_W          = 10,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] LFSR_SEED      = 32'hACE1_F00D
) (
    input  logic                      clk_i,
    input  logic                      sw_rst_i,
    input  logic                      start_i,
    input  logic [1:0]                mode_i,
    input  logic [TXN_W-1:0]          txn_num_i,
    input  logic                      op_ready_i,
    output logic                      op_val_o,
    output logic [4*DATA_WIDTH-1:0]   op_data_o,
    input  logic                      res_val_i,
    output logic                      res_ready_o,
    input  logic [4*DATA_WIDTH+3:0]   res_data_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      timeout_o,
    output logic [TXN_W-1:0]          pass_cnt_o,
    output logic [TXN_W-1:0]          err_cnt_o
);

    localparam int unsigned ResW = res_width(DATA_WIDTH);
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    state_e                   state_q, state_d;
    logic [1:0]               mode_q, mode_d;
    logic [TXN_W-1:0]         txn_num_q, txn_num_d;
    logic [TXN_W-1:0]         txn_cnt_q, txn_cnt_d;
    logic [TXN_W-1:0]         pass_q, pass_d;
    logic [TXN_W-1:0]         err_q, err_d;
    logic [GapW-1:0]          gap_q, gap_d;
    logic [TmoW-1:0]          tmo_q, tmo_d;
    logic                     timeout_q, timeout_d;
    logic [4*DATA_WIDTH-1:0]  op_q, op_d;
    logic signed [ResW-1:0]   exp_re_q, exp_re_d;
    logic signed [ResW-1:0]   exp_im_q, exp_im_d;
    logic [2*ResW-1:0]        res_q, res_d;

    logic                     lfsr_adv;
    logic [31:0]              lfsr_state;
    logic [4*DATA_WIDTH-1:0]  ops_new;
    logic signed [ResW-1:0]   a_x, b_x, c_x, d_x;

    complex_mult_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (sw_rst_i),
        .adv_i   (lfsr_adv),
        .state_o (lfsr_state)
    );

    always_comb begin
        unique case (mode_q)
            MODE_FIXED:  ops_new = {DATA_WIDTH'(2), DATA_WIDTH'(3), DATA_WIDTH'(4), DATA_WIDTH'(2)};
            MODE_RANDOM: ops_new = lfsr_state[4*DATA_WIDTH-1:0];
            MODE_ONES:   ops_new = '1;
            default:     ops_new = {4{{1'b1, {(DATA_WIDTH - 1){1'b0}}}}};
        endcase
    end

    // Operands are sign-extended before multiplying so products are exact at ResW.
    assign a_x = ResW'($signed(ops_new[4*DATA_WIDTH-1 -: DATA_WIDTH]));
    assign b_x = ResW'($signed(ops_new[3*DATA_WIDTH-1 -: DATA_WIDTH]));
    assign c_x = ResW'($signed(ops_new[2*DATA_WIDTH-1 -: DATA_WIDTH]));
    assign d_x = ResW'($signed(ops_new[DATA_WIDTH-1 -: DATA_WIDTH]));

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        txn_num_d = txn_num_q;
        txn_cnt_d = txn_cnt_q;
        pass_d    = pass_q;
        err_d     = err_q;
        gap_d     = gap_q;
        timeout_d = timeout_q;
        op_d      = op_q;
        exp_re_d  = exp_re_q;
        exp_im_d  = exp_im_q;
        res_d     = res_q;
        lfsr_adv  = 1'b0;
        tmo_d     = '0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    mode_d    = mode_i;
                    txn_num_d = txn_num_i;
                    txn_cnt_d = '0;
                    pass_d    = '0;
                    err_d     = '0;
                    timeout_d = 1'b0;
                    state_d   = (txn_num_i == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                op_d     = ops_new;
                exp_re_d = a_x * c_x - b_x * d_x;
                exp_im_d = a_x * d_x + b_x * c_x;
                lfsr_adv = (mode_q == MODE_RANDOM);
                gap_d    = '0;
                state_d  = (GAP_CYCLES == 0) ? StDrive : StGap;
            end
            StGap: begin
                gap_d = gap_q + 1'b1;
                if (int'(gap_q) + 1 >= int'(GAP_CYCLES)) begin
                    state_d = StDrive;
                end
            end
            StDrive: begin
                if (op_ready_i) begin
                    state_d = StWaitRes;
                end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StWaitRes: begin
                if (res_val_i) begin
                    res_d   = res_data_i;
                    state_d = StCheck;
                end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StCheck: begin
                if (res_q == {exp_re_q, exp_im_q}) begin
                    if (pass_q != '1) pass_d = pass_q + 1'b1;
                end else if (err_q != '1) begin
                    err_d = err_q + 1'b1;
                end
                txn_cnt_d = txn_cnt_q + 1'b1;
                state_d   = (txn_cnt_d < txn_num_q) ? StLoad : StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Handshake watchdog restarts whenever a waiting state is (re)entered.
        if ((state_q == StDrive || state_q == StWaitRes) && state_d == state_q) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (sw_rst_i) begin
            state_q   <= StIdle;
            mode_q    <= MODE_FIXED;
            txn_num_q <= '0;
            txn_cnt_q <= '0;
            pass_q    <= '0;
            err_q     <= '0;
            gap_q     <= '0;
            tmo_q     <= '0;
            timeout_q <= 1'b0;
            op_q      <= '0;
            exp_re_q  <= '0;
            exp_im_q  <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            txn_num_q <= txn_num_d;
            txn_cnt_q <= txn_cnt_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            gap_q     <= gap_d;
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
            op_q      <= op_d;
            exp_re_q  <= exp_re_d;
            exp_im_q  <= exp_im_d;
            res_q     <= res_d;
        end
    end

    assign op_val_o    = (state_q == StDrive);
    assign res_ready_o = (state_q == StWaitRes);
    assign busy_o      = (state_q != StIdle) && (state_q != StDone);
    assign done_o      = (state_q == StDone);
    assign timeout_o   = timeout_q;
    assign op_data_o   = op_q;
    assign pass_cnt_o  = pass_q;
    assign err_cnt_o   = err_q;

endmodule

// File: tb/tb_complex_mult_traffic_gen.sv
// Bench for complex_mult_traffic_gen: acts as the multiplier under test and checks the
// generator's operands, handshakes, counters and timeout against a plain-arithmetic model.
module tb_complex_mult_traffic_gen;

    localparam int          DW   = 8;
    localparam int          TW   = 10;
    localparam int          GAP  = 2;
    localparam int          TMO  = 255;
    localparam logic [31:0] SEED = 32'hACE1_F00D;

    logic          clk = 1'b0;
    logic          sw_rst;
    logic          start;
    logic [1:0]    mode;
    logic [TW-1:0] txn_num;
    logic          op_ready;
    logic          op_val;
    logic [31:0]   op_data;
    logic          res_val;
    logic          res_ready;
    logic [35:0]   res_data;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [TW-1:0] pass_cnt;
    logic [TW-1:0] err_cnt;

    int          errors = 0;
    int          checks = 0;
    int unsigned lfsr_m;

    always #5 clk = ~clk;

    complex_mult_traffic_gen #(
        .DATA_WIDTH     (DW),
        .TXN_W          (TW),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .LFSR_SEED      (SEED)
    ) dut (
        .clk_i       (clk),
        .sw_rst_i    (sw_rst),
        .start_i     (start),
        .mode_i      (mode),
        .txn_num_i   (txn_num),
        .op_ready_i  (op_ready),
        .op_val_o    (op_val),
        .op_data_o   (op_data),
        .res_val_i   (res_val),
        .res_ready_o (res_ready),
        .res_data_i  (res_data),
        .busy_o      (busy),
        .done_o      (done),
        .timeout_o   (timeout),
        .pass_cnt_o  (pass_cnt),
        .err_cnt_o   (err_cnt)
    );

    // ---------------- reference model ----------------
    function automatic logic [35:0] golden(input logic [31:0] ops);
        int a, b, c, d, re, im;
        logic [17:0] re_t, im_t;
        a = int'($signed(ops[31:24]));
        b = int'($signed(ops[23:16]));
        c = int'($signed(ops[15:8]));
        d = int'($signed(ops[7:0]));
        re = a * c - b * d;
        im = a * d + b * c;
        re_t = re[17:0];
        im_t = im[17:0];
        return {re_t, im_t};
    endfunction

    function automatic logic [31:0] next_ops(input logic [1:0] m);
        logic [31:0] r;
        case (m)
            2'd0: r = 32'h0203_0402;
            2'd1: begin
                r = lfsr_m;
                if ((lfsr_m & 32'd1) != 0) lfsr_m = (lfsr_m >> 1) ^ 32'h8020_0003;
                else lfsr_m = lfsr_m >> 1;
            end
            2'd2: r = 32'hFFFF_FFFF;
            default: r = 32'h8080_8080;
        endcase
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sw_rst   = 1'b1;
        start    = 1'b0;
        mode     = 2'd0;
        txn_num  = '0;
        op_ready = 1'b0;
        res_val  = 1'b0;
        res_data = '0;
        repeat (3) tick();
        sw_rst = 1'b0;
        lfsr_m = SEED;
    endtask

    task automatic start_run(input logic [1:0] m, input int n);
        mode    = m;
        txn_num = TW'(n);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Plays the multiplier for one transaction; returns what was seen on op_data.
    task automatic serve_txn(input bit stall, input bit corrupt, input bit ovr_en,
                             input logic [35:0] ovr, output logic [31:0] seen,
                             output bit stable, output bit got_op);
        bit rdy;
        got_op = 1'b0;
        stable = 1'b1;
        seen   = '0;
        for (int i = 0; i < 40; i++) begin
            if (op_val === 1'b1) break;
            tick();
        end
        if (op_val !== 1'b1) return;
        got_op = 1'b1;
        seen   = op_data;
        rdy    = stall ? 1'b0 : 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (op_data !== seen || op_val !== 1'b1) stable = 1'b0;
            op_ready = rdy;
            tick();
            if (rdy) break;
            rdy = stall ? ~rdy : 1'b1;
        end
        op_ready = 1'b0;
        if (stall) tick();
        res_data = ovr_en ? ovr : (golden(seen) ^ {35'd0, corrupt});
        res_val  = 1'b1;
        tick();
        res_val  = 1'b0;
        res_data = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({op_val, res_ready, busy, done, timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {op_val, res_ready, busy, done, timeout});
        end
        checks++;
        if (op_data !== 32'h0 || pass_cnt !== '0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL reset_data: got op=%h pass=%0d err=%0d want all 0",
                     op_data, pass_cnt, err_cnt);
        end
    endtask

    task automatic test_fixed();
        logic [31:0] seen;
        bit stable, got;
        int lat;
        start_run(2'd0, 1);
        mode    = 2'd2;
        txn_num = TW'(5);
        lat = 1;
        while (op_val !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 2 + GAP) begin
            errors++;
            $display("FAIL t1_latency: got %0d want %0d", lat, 2 + GAP);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_busy: got %b want 1", busy);
        end
        serve_txn(1'b0, 1'b0, 1'b1, {18'd2, 18'd16}, seen, stable, got);
        checks++;
        if (!got || seen !== 32'h0203_0402) begin
            errors++;
            $display("FAIL t1_op_data: got %h want 02030402", seen);
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass_cnt !== 10'd1 || err_cnt !== 10'd0) begin
            errors++;
            $display("FAIL t1_done: got done=%b busy=%b pass=%0d err=%0d want 1 0 1 0",
                     done, busy, pass_cnt, err_cnt);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL t1_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_ones();
        logic [31:0] seen;
        bit stable, got;
        start_run(2'd2, 1);
        serve_txn(1'b0, 1'b0, 1'b1, {18'd0, 18'd2}, seen, stable, got);
        checks++;
        if (!got || seen !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL t2_op_data: got %h want ffffffff", seen);
        end
        tick();
        checks++;
        if (pass_cnt !== 10'd1 || err_cnt !== 10'd0) begin
            errors++;
            $display("FAIL t2_pass: got pass=%0d err=%0d want 1 0", pass_cnt, err_cnt);
        end
        tick();
        start_run(2'd2, 1);
        serve_txn(1'b0, 1'b0, 1'b1, {18'd0, 18'd3}, seen, stable, got);
        tick();
        checks++;
        if (pass_cnt !== 10'd0 || err_cnt !== 10'd1 || done !== 1'b1) begin
            errors++;
            $display("FAIL t2_err: got pass=%0d err=%0d done=%b want 0 1 1",
                     pass_cnt, err_cnt, done);
        end
        tick();
    endtask

    task automatic test_minneg();
        logic [31:0] seen;
        bit stable, got;
        start_run(2'd3, 1);
        serve_txn(1'b0, 1'b0, 1'b1, {18'd0, 18'd32768}, seen, stable, got);
        checks++;
        if (!got || seen !== 32'h8080_8080) begin
            errors++;
            $display("FAIL t3_op_data: got %h want 80808080", seen);
        end
        tick();
        checks++;
        if (pass_cnt !== 10'd1 || err_cnt !== 10'd0) begin
            errors++;
            $display("FAIL t3_pass: got pass=%0d err=%0d want 1 0", pass_cnt, err_cnt);
        end
        tick();
    endtask

    task automatic test_random_stall();
        logic [31:0] seen, prev, exp;
        bit stable, got;
        prev = '0;
        start_run(2'd1, 3);
        for (int k = 0; k < 3; k++) begin
            exp = next_ops(2'd1);
            serve_txn(1'b1, 1'b0, 1'b0, '0, seen, stable, got);
            checks++;
            if (!got || seen !== exp) begin
                errors++;
                $display("FAIL t4_op_data[%0d]: got %h want %h", k, seen, exp);
            end
            checks++;
            if (!stable) begin
                errors++;
                $display("FAIL t4_stable[%0d]: got unstable op_data want stable", k);
            end
            if (k > 0) begin
                checks++;
                if (seen === prev) begin
                    errors++;
                    $display("FAIL t4_distinct[%0d]: got %h repeated want new set", k, seen);
                end
            end
            prev = seen;
            if (k == 0) begin
                // start while busy must not disturb the run
                mode  = 2'd0;
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        tick();
        checks++;
        if (done !== 1'b1 || pass_cnt !== 10'd3 || err_cnt !== 10'd0) begin
            errors++;
            $display("FAIL t4_counts: got done=%b pass=%0d err=%0d want 1 3 0",
                     done, pass_cnt, err_cnt);
        end
        tick();
    endtask

    task automatic test_zero_txn();
        start_run(2'd0, 0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || op_val !== 1'b0) begin
            errors++;
            $display("FAIL zero_txn: got done=%b busy=%b op_val=%b want 1 0 0",
                     done, busy, op_val);
        end
        tick();
    endtask

    task automatic test_timeout();
        logic [31:0] seen;
        bit stable, got;
        int cnt;
        start_run(2'd0, 1);
        op_ready = 1'b0;
        for (int i = 0; i < 20 && op_val !== 1'b1; i++) tick();
        cnt = 0;
        while (op_val === 1'b1 && cnt < 400) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt !== TMO) begin
            errors++;
            $display("FAIL t5_drive_cycles: got %0d want %0d", cnt, TMO);
        end
        checks++;
        if (done !== 1'b1 || timeout !== 1'b1 || pass_cnt !== '0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL t5_abort: got done=%b tmo=%b pass=%0d err=%0d want 1 1 0 0",
                     done, timeout, pass_cnt, err_cnt);
        end
        tick();
        checks++;
        if (timeout !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t5_sticky: got tmo=%b done=%b busy=%b want 1 0 0",
                     timeout, done, busy);
        end
        // result-side watchdog
        start_run(2'd0, 1);
        for (int i = 0; i < 20 && op_val !== 1'b1; i++) tick();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        cnt = 0;
        while (res_ready === 1'b1 && cnt < 400) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt !== TMO || timeout !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL t5_res_timeout: got cycles=%0d tmo=%b done=%b want %0d 1 1",
                     cnt, timeout, done, TMO);
        end
        tick();
        start_run(2'd2, 1);
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL t5_clear_on_start: got %b want 0", timeout);
        end
        serve_txn(1'b0, 1'b0, 1'b0, '0, seen, stable, got);
        tick();
        tick();
    endtask

    task automatic test_reset_midrun();
        logic [31:0] seen;
        bit stable, got;
        start_run(2'd0, 1);
        for (int i = 0; i < 20 && op_val !== 1'b1; i++) tick();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        checks++;
        if (res_ready !== 1'b1) begin
            errors++;
            $display("FAIL t6_in_wait_res: got res_ready=%b want 1", res_ready);
        end
        tick();
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        lfsr_m = SEED;
        checks++;
        if ({op_val, res_ready, busy, done, timeout} !== 5'b0 || op_data !== 32'h0 ||
            pass_cnt !== '0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL t6_reset: got flags=%b op=%h pass=%0d err=%0d want all 0",
                     {op_val, res_ready, busy, done, timeout}, op_data, pass_cnt, err_cnt);
        end
        start_run(2'd0, 2);
        for (int k = 0; k < 2; k++) begin
            serve_txn(1'b0, 1'b0, 1'b0, '0, seen, stable, got);
        end
        tick();
        checks++;
        if (done !== 1'b1 || pass_cnt !== 10'd2 || err_cnt !== 10'd0) begin
            errors++;
            $display("FAIL t6_restart: got done=%b pass=%0d err=%0d want 1 2 0",
                     done, pass_cnt, err_cnt);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] seen, exp;
        bit stable, got, bad, st;
        logic [1:0] m;
        int n, exp_pass, exp_err;
        for (int r = 0; r < 4; r++) begin
            m = 2'($urandom_range(0, 3));
            n = int'($urandom_range(2, 5));
            exp_pass = 0;
            exp_err  = 0;
            start_run(m, n);
            for (int k = 0; k < n; k++) begin
                exp = next_ops(m);
                bad = ($urandom_range(0, 2) == 0);
                st  = 1'($urandom_range(0, 1));
                serve_txn(st, bad, 1'b0, '0, seen, stable, got);
                if (bad) exp_err++;
                else exp_pass++;
                checks++;
                if (!got || seen !== exp) begin
                    errors++;
                    $display("FAIL b2b_op_data[%0d.%0d]: got %h want %h", r, k, seen, exp);
                end
            end
            tick();
            checks++;
            if (done !== 1'b1 || int'(pass_cnt) !== exp_pass || int'(err_cnt) !== exp_err) begin
                errors++;
                $display("FAIL b2b_counts[%0d]: got done=%b pass=%0d err=%0d want 1 %0d %0d",
                         r, done, pass_cnt, err_cnt, exp_pass, exp_err);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_ones();
        test_minneg();
        test_random_stall();
        test_zero_txn();
        test_timeout();
        test_reset_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
